// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main control unit.
//
// Sequences each instruction held in the IR through fetch, decode, execute,
// memory and writeback states. It drives the ALU operation code, the operand
// selects and every datapath strobe. It stalls in FETCH, MEM_RD and MEM_WR
// until the memory returns ready.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          synchronous active-high reset; forces every output except
//                  o_state to 0 while high
//   i_opcode       IR[31:26]
//   i_funct        IR[5:0]
//   i_alu_zero     ALU result == 0 (used only in BRANCH)
//   i_mem_ready    memory access completes this cycle
//   o_mem_req      memory request, held until ready
//   o_mem_wen      store
//   o_iord         address source: 0 PC, 1 ALUOut
//   o_ir_write     load the IR
//   o_pc_write     load the PC (branch condition already folded in)
//   o_pc_src       0 ALU, 1 ALUOut, 2 jump target, 3 A reg
//   o_reg_write    register-file write enable
//   o_reg_dst      0 rt, 1 rd, 2 r31
//   o_mem_to_reg   0 ALUOut, 1 MDR, 2 PC
//   o_alu_src_a    0 PC, 1 A, 2 IR-derived immediate (shamt)
//   o_alu_src_b    0 B, 1 constant 4, 2 extended imm, 3 sign-ext imm << 2
//   o_zero_ext     zero-extend the immediate
//   o_alu_ctrl     ALU operation code
//   o_illegal      one-cycle pulse on an unsupported instruction
//   o_state        current state, for debug

module mc_ctrl_fsm (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_alu_zero,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_wen,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_zero_ext,
  output logic [3:0] o_alu_ctrl,
  output logic       o_illegal,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StIExec   = 4'd9,
    StIWb     = 4'd10,
    StJump    = 4'd11,
    StJr      = 4'd12
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluXor = 4'b0100;
  localparam logic [3:0] AluNor = 4'b0101;
  localparam logic [3:0] AluSlt = 4'b0110;
  localparam logic [3:0] AluSll = 4'b1000;
  localparam logic [3:0] AluSrl = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1011;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  state_e r_state;
  state_e w_state_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign o_state = r_state;

  always_comb begin
    w_state_next = StFetch;
    o_mem_req    = 1'b0;
    o_mem_wen    = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'd0;
    o_reg_write  = 1'b0;
    o_reg_dst    = 2'd0;
    o_mem_to_reg = 2'd0;
    o_alu_src_a  = 2'd0;
    o_alu_src_b  = 2'd0;
    o_zero_ext   = 1'b0;
    o_alu_ctrl   = AluAdd;
    o_illegal    = 1'b0;

    case (r_state)
      StFetch: begin
        o_mem_req   = 1'b1;
        o_alu_src_b = 2'd1;
        // IR/PC strobes only on the ready cycle so a stall never double-loads.
        if (i_mem_ready) begin
          o_ir_write   = 1'b1;
          o_pc_write   = 1'b1;
          w_state_next = StDecode;
        end else begin
          w_state_next = StFetch;
        end
      end

      StDecode: begin
        // Branch target computed speculatively into ALUOut.
        o_alu_src_b = 2'd3;
        case (i_opcode)
          OpLw, OpSw:   w_state_next = StMemAddr;
          OpBeq, OpBne: w_state_next = StBranch;
          OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpXori: w_state_next = StIExec;
          OpJ, OpJal:   w_state_next = StJump;
          OpRType: begin
            case (i_funct)
              6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2A, 6'h00, 6'h02, 6'h03: w_state_next = StRExec;
              6'h08:                      w_state_next = StJr;
              default: begin
                o_illegal    = 1'b1;
                w_state_next = StFetch;
              end
            endcase
          end
          default: begin
            o_illegal    = 1'b1;
            w_state_next = StFetch;
          end
        endcase
      end

      StMemAddr: begin
        o_alu_src_a  = 2'd1;
        o_alu_src_b  = 2'd2;
        w_state_next = (i_opcode == OpLw) ? StMemRd : StMemWr;
      end

      StMemRd: begin
        o_mem_req    = 1'b1;
        o_iord       = 1'b1;
        w_state_next = i_mem_ready ? StMemWb : StMemRd;
      end

      StMemWb: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 2'd1;
        w_state_next = StFetch;
      end

      StMemWr: begin
        o_mem_req    = 1'b1;
        o_mem_wen    = 1'b1;
        o_iord       = 1'b1;
        w_state_next = i_mem_ready ? StFetch : StMemWr;
      end

      StRExec: begin
        o_alu_src_a = 2'd1;
        case (i_funct)
          6'h20, 6'h21: o_alu_ctrl = AluAdd;
          6'h22, 6'h23: o_alu_ctrl = AluSub;
          6'h24:        o_alu_ctrl = AluAnd;
          6'h25:        o_alu_ctrl = AluOr;
          6'h26:        o_alu_ctrl = AluXor;
          6'h27:        o_alu_ctrl = AluNor;
          6'h2A:        o_alu_ctrl = AluSlt;
          // Shifts take shamt from the IR instead of the A register.
          6'h00: begin
            o_alu_ctrl  = AluSll;
            o_alu_src_a = 2'd2;
          end
          6'h02: begin
            o_alu_ctrl  = AluSrl;
            o_alu_src_a = 2'd2;
          end
          6'h03: begin
            o_alu_ctrl  = AluSra;
            o_alu_src_a = 2'd2;
          end
          default:      o_alu_ctrl = AluAdd;
        endcase
        w_state_next = StRWb;
      end

      StRWb: begin
        o_reg_write  = 1'b1;
        o_reg_dst    = 2'd1;
        w_state_next = StFetch;
      end

      StBranch: begin
        o_alu_src_a  = 2'd1;
        o_alu_ctrl   = AluSub;
        o_pc_src     = 2'd1;
        o_pc_write   = (i_opcode == OpBeq) ? i_alu_zero : ~i_alu_zero;
        w_state_next = StFetch;
      end

      StIExec: begin
        o_alu_src_a = 2'd1;
        o_alu_src_b = 2'd2;
        case (i_opcode)
          OpSlti: o_alu_ctrl = AluSlt;
          OpAndi: begin
            o_alu_ctrl = AluAnd;
            o_zero_ext = 1'b1;
          end
          OpOri: begin
            o_alu_ctrl = AluOr;
            o_zero_ext = 1'b1;
          end
          OpXori: begin
            o_alu_ctrl = AluXor;
            o_zero_ext = 1'b1;
          end
          default: o_alu_ctrl = AluAdd;
        endcase
        w_state_next = StIWb;
      end

      StIWb: begin
        o_reg_write  = 1'b1;
        w_state_next = StFetch;
      end

      StJump: begin
        o_pc_write = 1'b1;
        o_pc_src   = 2'd2;
        // PC already holds PC+4 from FETCH, so the link value is the PC itself.
        if (i_opcode == OpJal) begin
          o_reg_write  = 1'b1;
          o_reg_dst    = 2'd2;
          o_mem_to_reg = 2'd2;
        end
        w_state_next = StFetch;
      end

      StJr: begin
        o_pc_write   = 1'b1;
        o_pc_src     = 2'd3;
        w_state_next = StFetch;
      end

      default: w_state_next = StFetch;
    endcase

    // Reset masks all strobes so an abandoned access or write cannot leak out.
    if (i_rst) begin
      o_mem_req    = 1'b0;
      o_mem_wen    = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 2'd0;
      o_reg_write  = 1'b0;
      o_reg_dst    = 2'd0;
      o_mem_to_reg = 2'd0;
      o_alu_src_a  = 2'd0;
      o_alu_src_b  = 2'd0;
      o_zero_ext   = 1'b0;
      o_alu_ctrl   = AluAdd;
      o_illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: table-driven bench for mc_ctrl_fsm. Each table record holds
// the inputs for one clock cycle plus the state and packed output word the
// DUT must show in that cycle. Cycle-count sequences follow the table.
module tb_mc_ctrl_fsm;

  logic       i_clk;
  logic       i_rst;
  logic [5:0] i_opcode;
  logic [5:0] i_funct;
  logic       i_alu_zero;
  logic       i_mem_ready;
  logic       o_mem_req;
  logic       o_mem_wen;
  logic       o_iord;
  logic       o_ir_write;
  logic       o_pc_write;
  logic [1:0] o_pc_src;
  logic       o_reg_write;
  logic [1:0] o_reg_dst;
  logic [1:0] o_mem_to_reg;
  logic [1:0] o_alu_src_a;
  logic [1:0] o_alu_src_b;
  logic       o_zero_ext;
  logic [3:0] o_alu_ctrl;
  logic       o_illegal;
  logic [3:0] o_state;

  mc_ctrl_fsm u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_opcode     (i_opcode),
    .i_funct      (i_funct),
    .i_alu_zero   (i_alu_zero),
    .i_mem_ready  (i_mem_ready),
    .o_mem_req    (o_mem_req),
    .o_mem_wen    (o_mem_wen),
    .o_iord       (o_iord),
    .o_ir_write   (o_ir_write),
    .o_pc_write   (o_pc_write),
    .o_pc_src     (o_pc_src),
    .o_reg_write  (o_reg_write),
    .o_reg_dst    (o_reg_dst),
    .o_mem_to_reg (o_mem_to_reg),
    .o_alu_src_a  (o_alu_src_a),
    .o_alu_src_b  (o_alu_src_b),
    .o_zero_ext   (o_zero_ext),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_illegal    (o_illegal),
    .o_state      (o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Packed output word layout:
  // [21] mem_req [20] mem_wen [19] iord [18] ir_write [17] pc_write
  // [16:15] pc_src [14] reg_write [13:12] reg_dst [11:10] mem_to_reg
  // [9:8] alu_src_a [7:6] alu_src_b [5] zero_ext [4:1] alu_ctrl [0] illegal
  localparam logic [21:0] MREQ = 22'h200000;
  localparam logic [21:0] MWEN = 22'h100000;
  localparam logic [21:0] IORD = 22'h080000;
  localparam logic [21:0] IRW  = 22'h040000;
  localparam logic [21:0] PCW  = 22'h020000;
  localparam logic [21:0] RW   = 22'h004000;
  localparam logic [21:0] ZEXT = 22'h000020;
  localparam logic [21:0] ILL  = 22'h000001;
  localparam int L_PCS  = 15;
  localparam int L_RDST = 12;
  localparam int L_MTR  = 10;
  localparam int L_SRCA = 8;
  localparam int L_SRCB = 6;
  localparam int L_ALU  = 1;

  function automatic logic [21:0] fld(input int v, input int lsb);
    return 22'(v) << lsb;
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [3:0]  st;
    logic [21:0] out;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic rdy, input logic [3:0] st,
                     input logic [21:0] out);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  function automatic logic [21:0] dut_out();
    return {o_mem_req, o_mem_wen, o_iord, o_ir_write, o_pc_write, o_pc_src,
            o_reg_write, o_reg_dst, o_mem_to_reg, o_alu_src_a, o_alu_src_b,
            o_zero_ext, o_alu_ctrl, o_illegal};
  endfunction

  // Starting in FETCH with zero-wait memory, count edges until FETCH again.
  task automatic count_cycles(input string name, input logic [5:0] op,
                              input logic [5:0] fn, input int exp);
    int n;
    i_rst = 1'b0; i_opcode = op; i_funct = fn; i_alu_zero = 1'b0; i_mem_ready = 1'b1;
    n = 0;
    do begin
      @(posedge i_clk); #1;
      n++;
    end while (o_state != 4'd0 && n < 20);
    n_checks++;
    if (n != exp) begin
      n_fail++;
      $display("FAIL cycles_%s: got %0d cycles, want %0d", name, n, exp);
    end
  endtask

  initial begin
    logic [21:0] f_rdy, f_wait, dec, br, rwb, ms_wr;
    n_checks = 0;
    n_fail   = 0;
    f_rdy  = MREQ | IRW | PCW | fld(1, L_SRCB);
    f_wait = MREQ | fld(1, L_SRCB);
    dec    = fld(3, L_SRCB);
    br     = fld(1, L_SRCA) | fld(1, L_ALU) | fld(1, L_PCS);
    rwb    = RW | fld(1, L_RDST);
    ms_wr  = MREQ | MWEN | IORD;

    // Reset: state FETCH, all outputs masked even with mem_ready high.
    add(1, 6'h00, 6'h20, 0, 1, 0, 22'h0);
    add(1, 6'h00, 6'h20, 0, 1, 0, 22'h0);
    // add, with one fetch wait cycle
    add(0, 6'h00, 6'h20, 0, 0, 0, f_wait);
    add(0, 6'h00, 6'h20, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h20, 0, 1, 1, dec);
    add(0, 6'h00, 6'h20, 0, 1, 6, fld(1, L_SRCA) | fld(0, L_ALU));
    add(0, 6'h00, 6'h20, 0, 1, 7, rwb);
    // lw, 3 stall cycles in MEM_RD; mem_ready low in DECODE is ignored
    add(0, 6'h23, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h23, 6'h00, 0, 0, 1, dec);
    add(0, 6'h23, 6'h00, 0, 1, 2, fld(1, L_SRCA) | fld(2, L_SRCB));
    add(0, 6'h23, 6'h00, 0, 0, 3, MREQ | IORD);
    add(0, 6'h23, 6'h00, 0, 0, 3, MREQ | IORD);
    add(0, 6'h23, 6'h00, 0, 0, 3, MREQ | IORD);
    add(0, 6'h23, 6'h00, 0, 1, 3, MREQ | IORD);
    add(0, 6'h23, 6'h00, 0, 1, 4, RW | fld(1, L_MTR));
    // beq taken, bne not taken, bne taken
    add(0, 6'h04, 6'h00, 1, 1, 0, f_rdy);
    add(0, 6'h04, 6'h00, 1, 1, 1, dec);
    add(0, 6'h04, 6'h00, 1, 1, 8, br | PCW);
    add(0, 6'h05, 6'h00, 1, 1, 0, f_rdy);
    add(0, 6'h05, 6'h00, 1, 1, 1, dec);
    add(0, 6'h05, 6'h00, 1, 1, 8, br);
    add(0, 6'h05, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h05, 6'h00, 0, 1, 1, dec);
    add(0, 6'h05, 6'h00, 0, 1, 8, br | PCW);
    // R-type ALU decodes: sub, sll, sra, nor, slt
    add(0, 6'h00, 6'h22, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h22, 0, 1, 1, dec);
    add(0, 6'h00, 6'h22, 0, 1, 6, fld(1, L_SRCA) | fld(1, L_ALU));
    add(0, 6'h00, 6'h22, 0, 1, 7, rwb);
    add(0, 6'h00, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h00, 0, 1, 1, dec);
    add(0, 6'h00, 6'h00, 0, 1, 6, fld(2, L_SRCA) | fld(8, L_ALU));
    add(0, 6'h00, 6'h00, 0, 1, 7, rwb);
    add(0, 6'h00, 6'h03, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h03, 0, 1, 1, dec);
    add(0, 6'h00, 6'h03, 0, 1, 6, fld(2, L_SRCA) | fld(11, L_ALU));
    add(0, 6'h00, 6'h03, 0, 1, 7, rwb);
    add(0, 6'h00, 6'h27, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h27, 0, 1, 1, dec);
    add(0, 6'h00, 6'h27, 0, 1, 6, fld(1, L_SRCA) | fld(5, L_ALU));
    add(0, 6'h00, 6'h27, 0, 1, 7, rwb);
    add(0, 6'h00, 6'h2A, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h2A, 0, 1, 1, dec);
    add(0, 6'h00, 6'h2A, 0, 1, 6, fld(1, L_SRCA) | fld(6, L_ALU));
    add(0, 6'h00, 6'h2A, 0, 1, 7, rwb);
    // ori (zero-extended), slti (sign-extended)
    add(0, 6'h0D, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h0D, 6'h00, 0, 1, 1, dec);
    add(0, 6'h0D, 6'h00, 0, 1, 9, fld(1, L_SRCA) | fld(2, L_SRCB) | ZEXT | fld(3, L_ALU));
    add(0, 6'h0D, 6'h00, 0, 1, 10, RW);
    add(0, 6'h0A, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h0A, 6'h00, 0, 1, 1, dec);
    add(0, 6'h0A, 6'h00, 0, 1, 9, fld(1, L_SRCA) | fld(2, L_SRCB) | fld(6, L_ALU));
    add(0, 6'h0A, 6'h00, 0, 1, 10, RW);
    // jal, j, jr
    add(0, 6'h03, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h03, 6'h00, 0, 1, 1, dec);
    add(0, 6'h03, 6'h00, 0, 1, 11, PCW | fld(2, L_PCS) | RW | fld(2, L_RDST) | fld(2, L_MTR));
    add(0, 6'h02, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h02, 6'h00, 0, 1, 1, dec);
    add(0, 6'h02, 6'h00, 0, 1, 11, PCW | fld(2, L_PCS));
    add(0, 6'h00, 6'h08, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h08, 0, 1, 1, dec);
    add(0, 6'h00, 6'h08, 0, 1, 12, PCW | fld(3, L_PCS));
    // illegal opcode 0x3F and illegal R-type funct 0x01
    add(0, 6'h3F, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h3F, 6'h00, 0, 1, 1, dec | ILL);
    add(0, 6'h00, 6'h01, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h01, 0, 1, 1, dec | ILL);
    // sw, zero-wait
    add(0, 6'h2B, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h2B, 6'h00, 0, 1, 1, dec);
    add(0, 6'h2B, 6'h00, 0, 1, 2, fld(1, L_SRCA) | fld(2, L_SRCB));
    add(0, 6'h2B, 6'h00, 0, 1, 5, ms_wr);
    // sw stalled, reset mid-stall, then a fresh add with no leftover store
    add(0, 6'h2B, 6'h00, 0, 1, 0, f_rdy);
    add(0, 6'h2B, 6'h00, 0, 1, 1, dec);
    add(0, 6'h2B, 6'h00, 0, 1, 2, fld(1, L_SRCA) | fld(2, L_SRCB));
    add(0, 6'h2B, 6'h00, 0, 0, 5, ms_wr);
    add(0, 6'h2B, 6'h00, 0, 0, 5, ms_wr);
    add(1, 6'h2B, 6'h00, 0, 0, 5, 22'h0);
    add(0, 6'h00, 6'h20, 0, 0, 0, f_wait);
    add(0, 6'h00, 6'h20, 0, 1, 0, f_rdy);
    add(0, 6'h00, 6'h20, 0, 1, 1, dec);
    add(0, 6'h00, 6'h20, 0, 1, 6, fld(1, L_SRCA));
    add(0, 6'h00, 6'h20, 0, 1, 7, rwb);

    i_rst = 1'b1; i_opcode = 6'h00; i_funct = 6'h20; i_alu_zero = 1'b0; i_mem_ready = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      i_rst       = vecs[i].rst;
      i_opcode    = vecs[i].op;
      i_funct     = vecs[i].fn;
      i_alu_zero  = vecs[i].z;
      i_mem_ready = vecs[i].rdy;
      #3;
      n_checks++;
      if (o_state !== vecs[i].st) begin
        n_fail++;
        $display("FAIL vec%0d state: got %0d want %0d", i, o_state, vecs[i].st);
      end
      n_checks++;
      if (dut_out() !== vecs[i].out) begin
        n_fail++;
        $display("FAIL vec%0d outputs: got %06h want %06h", i, dut_out(), vecs[i].out);
      end
      @(posedge i_clk); #1;
    end

    // Zero-wait cycle counts, each starting from FETCH.
    count_cycles("rtype", 6'h00, 6'h25, 4);
    count_cycles("itype", 6'h08, 6'h00, 4);
    count_cycles("lw",    6'h23, 6'h00, 5);
    count_cycles("sw",    6'h2B, 6'h00, 4);
    count_cycles("beq",   6'h04, 6'h00, 3);
    count_cycles("j",     6'h02, 6'h00, 3);
    count_cycles("jal",   6'h03, 6'h00, 3);
    count_cycles("jr",    6'h00, 6'h08, 3);
    count_cycles("ill",   6'h3F, 6'h00, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
